// File: rtl/seq_shifter_pkg.sv
// Shared encodings and default sizing for the iterative shift engine.
package seq_shifter_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_AMTW  = 4;

    typedef enum logic [1:0] {
        OP_ROR = 2'b00,
        OP_LSL = 2'b01,
        OP_LSR = 2'b10,
        OP_ASR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/seq_shifter_step.sv
// One-bit shift/rotate step; the top level iterates this once per clock.
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = x;
        case (op)
            OP_ROR:  y = {x[0], x[WIDTH-1:1]};
            OP_LSL:  y = {x[WIDTH-2:0], 1'b0};
            OP_LSR:  y = {1'b0, x[WIDTH-1:1]};
            OP_ASR:  y = {x[WIDTH-1], x[WIDTH-1:1]};
            default: y = x;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: captures operands on start, applies one bit step per clock.
//   state   | meaning
//   S_IDLE  | waiting for start, sout holds last result
//   S_SHIFT | cnt steps remaining, one applied per clock
//   S_DONE  | result valid, done pulses for this cycle
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMTW  = DEF_AMTW
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       op,
    input  logic [AMTW-1:0]  amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sout
);

    localparam logic [AMTW-1:0] CNT_ONE = AMTW'(1);

    state_t           state, state_nxt;
    op_t              opq, opq_nxt;
    logic [AMTW-1:0]  cnt, cnt_nxt;
    logic [WIDTH-1:0] sout_nxt;
    logic [WIDTH-1:0] step_y;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .x  (sout),
        .op (opq),
        .y  (step_y)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
            opq   <= OP_ROR;
            cnt   <= '0;
            sout  <= '0;
        end else begin
            state <= state_nxt;
            opq   <= opq_nxt;
            cnt   <= cnt_nxt;
            sout  <= sout_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        opq_nxt   = opq;
        cnt_nxt   = cnt;
        sout_nxt  = sout;
        case (state)
            S_IDLE: begin
                if (start) begin
                    sout_nxt  = in;
                    opq_nxt   = op_t'(op);
                    cnt_nxt   = amt;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt != '0) begin
                    sout_nxt = step_y;
                    cnt_nxt  = cnt - CNT_ONE;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Decoded from the state register only, so no input-to-output path.
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: vector table plus hand-written corner sequences.
module tb_seq_shifter;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] in;
    logic [1:0]  op;
    logic [3:0]  amt;
    logic        busy;
    logic        done;
    logic [15:0] sout;

    int n_checks = 0;
    int n_fail   = 0;

    seq_shifter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .in      (in),
        .op      (op),
        .amt     (amt),
        .busy    (busy),
        .done    (done),
        .sout    (sout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  amt;
        logic [15:0] in;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and watch it; sample k is taken just after edge E0+k.
    task automatic run_op(input logic [1:0] op_i, input logic [3:0] amt_i,
                          input logic [15:0] in_i, input logic [15:0] exp_i);
        int busy_cycles, done_cycles, done_at;
        logic [15:0] res;
        @(negedge clk);
        start = 1'b1; in = in_i; op = op_i; amt = amt_i;
        tick();
        start = 1'b0; in = ~in_i; op = ~op_i; amt = ~amt_i;
        busy_cycles = 0; done_cycles = 0; done_at = -1; res = '0;
        for (int k = 0; k <= int'(amt_i) + 5; k++) begin
            if (busy) busy_cycles++;
            if (done) begin
                done_cycles++;
                if (done_at < 0) begin
                    done_at = k;
                    res = sout;
                end
            end
            tick();
        end
        check($sformatf("result op=%0d amt=%0d", op_i, amt_i), 32'(res), 32'(exp_i));
        check($sformatf("done_latency op=%0d amt=%0d", op_i, amt_i), 32'(done_at), 32'(int'(amt_i) + 1));
        check($sformatf("done_count op=%0d amt=%0d", op_i, amt_i), 32'(done_cycles), 32'd1);
        check($sformatf("busy_width op=%0d amt=%0d", op_i, amt_i), 32'(busy_cycles), 32'(int'(amt_i) + 2));
        check($sformatf("result_hold op=%0d amt=%0d", op_i, amt_i), 32'(sout), 32'(exp_i));
    endtask

    initial begin
        int done_cycles, done_at, second_at;
        logic [15:0] res;

        vecs[0]  = '{2'b01, 4'd1,  16'h82C5, 16'h058A};
        vecs[1]  = '{2'b10, 4'd1,  16'h82C5, 16'h4162};
        vecs[2]  = '{2'b11, 4'd1,  16'h82C5, 16'hC162};
        vecs[3]  = '{2'b00, 4'd1,  16'h82C5, 16'hC162};
        vecs[4]  = '{2'b00, 4'd4,  16'h82C5, 16'h582C};
        vecs[5]  = '{2'b01, 4'd4,  16'h82C5, 16'h2C50};
        vecs[6]  = '{2'b11, 4'd15, 16'h82C5, 16'hFFFF};
        vecs[7]  = '{2'b10, 4'd15, 16'h82C5, 16'h0001};
        vecs[8]  = '{2'b01, 4'd0,  16'h1234, 16'h1234};
        vecs[9]  = '{2'b00, 4'd15, 16'h82C5, 16'h058B};
        vecs[10] = '{2'b10, 4'd4,  16'h82C5, 16'h082C};
        vecs[11] = '{2'b11, 4'd4,  16'h82C5, 16'hF82C};
        vecs[12] = '{2'b01, 4'd15, 16'h82C5, 16'h8000};

        reset_n = 1'b0; start = 1'b1; in = 16'hFFFF; op = 2'b01; amt = 4'd3;
        tick();
        tick();
        check("reset_sout", 32'(sout), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);

        @(negedge clk);
        start = 1'b0; reset_n = 1'b1;
        done_cycles = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done || busy) done_cycles++;
        end
        check("idle_after_reset_no_activity", 32'(done_cycles), 32'd0);

        for (int i = 0; i < 13; i++)
            run_op(vecs[i].op, vecs[i].amt, vecs[i].in, vecs[i].exp);

        // Second start mid-SHIFT must be ignored entirely.
        @(negedge clk);
        start = 1'b1; in = 16'h00F0; op = 2'b10; amt = 4'd4;
        tick();
        start = 1'b0;
        done_cycles = 0; done_at = -1; res = '0;
        for (int k = 0; k <= 12; k++) begin
            if (k == 2) begin
                start = 1'b1; in = 16'hFFFF; op = 2'b01; amt = 4'd1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_cycles++;
                if (done_at < 0) begin
                    done_at = k;
                    res = sout;
                end
            end
            tick();
        end
        check("ignored_start_result", 32'(res), 32'h000F);
        check("ignored_start_done_count", 32'(done_cycles), 32'd1);
        check("ignored_start_latency", 32'(done_at), 32'd5);

        // Held start re-triggers every amt+3 cycles.
        @(negedge clk);
        start = 1'b1; in = 16'h82C5; op = 2'b01; amt = 4'd1;
        tick();
        done_at = -1; second_at = -1;
        for (int k = 0; k <= 7; k++) begin
            if (done) begin
                if (done_at < 0) done_at = k;
                else if (second_at < 0) second_at = k;
            end
            tick();
        end
        start = 1'b0;
        check("retrigger_first_done", 32'(done_at), 32'd2);
        check("retrigger_second_done", 32'(second_at), 32'd6);
        for (int k = 0; k < 6; k++) tick();

        // Reset in the middle of a long operation.
        @(negedge clk);
        start = 1'b1; in = 16'h8000; op = 2'b11; amt = 4'd8;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("midop_busy_before_reset", 32'(busy), 32'h1);
        reset_n = 1'b0;
        tick();
        check("midop_reset_sout", 32'(sout), 32'h0);
        check("midop_reset_busy", 32'(busy), 32'h0);
        check("midop_reset_done", 32'(done), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        done_cycles = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (done) done_cycles++;
        end
        check("midop_reset_no_done", 32'(done_cycles), 32'd0);
        run_op(2'b11, 4'd1, 16'h8000, 16'hC000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
